ucsbece154b_bp_perfmon: RTL and testbench

//  In-hardware branch-predictor performance monitor. Moves the cycle, retire, branch, jump and BTB

---
 rtl/ucsbece154b_bp_perfmon_pkg.sv | 29 ++
 rtl/ucsbece154b_bp_perfmon_if.sv | 22 ++
 rtl/ucsbece154b_bp_perfmon_sat_counter.sv | 21 ++
 rtl/ucsbece154b_bp_perfmon.sv | 107 ++++++++++
 tb/tb_ucsbece154b_bp_perfmon.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ucsbece154b_bp_perfmon_pkg.sv
// Shared definitions for the branch-predictor performance monitor:
// counter map, read-port FSM states and the mispredict rule.
package ucsbece154b_perf_pkg;

  localparam int unsigned CNT_CYCLES    = 0;
  localparam int unsigned CNT_RETIRED   = 1;
  localparam int unsigned CNT_BRANCH    = 2;
  localparam int unsigned CNT_BR_MISP   = 3;
  localparam int unsigned CNT_JUMP      = 4;
  localparam int unsigned CNT_JMP_MISP  = 5;
  localparam int unsigned CNT_BTB_HIT   = 6;
  localparam int unsigned CNT_BTB_MISS  = 7;
  localparam int unsigned NUM_CNT       = 8;

  typedef enum logic [1:0] {IDLE, READ, ACK} perf_state_e;

  // Jumps are always taken, so only a missing prediction or a wrong target counts.
  function automatic logic is_mispredict(input logic        pred_taken,
                                         input logic        actual_taken,
                                         input logic [31:0] pred_target,
                                         input logic [31:0] actual_target,
                                         input logic        is_jump);
    if (is_jump)
      return !pred_taken || (pred_target != actual_target);
    return (pred_taken != actual_taken) ||
           (pred_taken && actual_taken && (pred_target != actual_target));
  endfunction

endpackage

// File: rtl/ucsbece154b_bp_perfmon_if.sv
// Host-side read/clear port of the performance monitor (four-phase handshake).
interface ucsbece154b_bp_perfmon_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 3
);
  logic              rd_req_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_ack_o;
  logic [CNT_W-1:0]  rd_data_o;
  logic              clr_req_i;
  logic              busy_o;

  modport master (
    output rd_req_i, rd_addr_i, clr_req_i,
    input  rd_ack_o, rd_data_o, busy_o
  );

  modport slave (
    input  rd_req_i, rd_addr_i, clr_req_i,
    output rd_ack_o, rd_data_o, busy_o
  );
endinterface

// File: rtl/ucsbece154b_bp_perfmon_sat_counter.sv
// Saturating event counter with synchronous clear and async active-low reset.
module ucsbece154b_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q_o <= '0;
    else if (clr_i)
      q_o <= '0;
    else if (inc_i && (q_o != '1))
      q_o <= q_o + W'(1);
  end

endmodule

// File: rtl/ucsbece154b_bp_perfmon.sv
// Branch-predictor performance monitor: per-cycle event decode, 8 saturating
// counters, a coherent snapshot taken on reads of counter 0, and the read FSM.
module ucsbece154b_bp_perfmon
  import ucsbece154b_perf_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic        retire_i,
  input  logic        valid_e_i,
  input  logic        branch_e_i,
  input  logic        jump_e_i,
  input  logic        pred_taken_e_i,
  input  logic        actual_taken_e_i,
  input  logic [31:0] pred_target_e_i,
  input  logic [31:0] actual_target_e_i,
  input  logic        btb_hit_e_i,
  ucsbece154b_bp_perfmon_if.slave rd_if
);

  perf_state_e          state;
  logic [NUM_CNT-1:0]   inc;
  logic                 clr_go;
  logic                 ev_br;
  logic                 ev_jmp;
  logic [CNT_W-1:0]     live [NUM_CNT];
  logic [CNT_W-1:0]     snap [NUM_CNT];

  // A branch that is also flagged as a jump is accounted as a jump only.
  always_comb begin
    ev_jmp = valid_e_i && jump_e_i;
    ev_br  = valid_e_i && branch_e_i && !jump_e_i;
    inc    = '0;
    inc[CNT_CYCLES]   = enable_i;
    inc[CNT_RETIRED]  = enable_i && retire_i;
    inc[CNT_BRANCH]   = enable_i && ev_br;
    inc[CNT_BR_MISP]  = enable_i && ev_br &&
                        is_mispredict(pred_taken_e_i, actual_taken_e_i,
                                      pred_target_e_i, actual_target_e_i, 1'b0);
    inc[CNT_JUMP]     = enable_i && ev_jmp;
    inc[CNT_JMP_MISP] = enable_i && ev_jmp &&
                        is_mispredict(pred_taken_e_i, actual_taken_e_i,
                                      pred_target_e_i, actual_target_e_i, 1'b1);
    inc[CNT_BTB_HIT]  = enable_i && (ev_br || ev_jmp) && btb_hit_e_i;
    inc[CNT_BTB_MISS] = enable_i && (ev_br || ev_jmp) && !btb_hit_e_i;
  end

  assign clr_go = rd_if.clr_req_i && (state == IDLE);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    ucsbece154b_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (clr_go),
      .inc_i (inc[i]),
      .q_o   (live[i])
    );
  end

  // A simultaneous clear and read request in IDLE takes the clear first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      rd_if.rd_ack_o  <= 1'b0;
      rd_if.busy_o    <= 1'b0;
      rd_if.rd_data_o <= '0;
      for (int unsigned i = 0; i < NUM_CNT; i++)
        snap[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_if.rd_req_i && !rd_if.clr_req_i) begin
            state        <= READ;
            rd_if.busy_o <= 1'b1;
          end
        end
        READ: begin
          if (rd_if.rd_addr_i == '0) begin
            for (int unsigned i = 0; i < NUM_CNT; i++)
              snap[i] <= live[i];
            rd_if.rd_data_o <= live[CNT_CYCLES];
          end else begin
            rd_if.rd_data_o <= snap[rd_if.rd_addr_i];
          end
          state          <= ACK;
          rd_if.rd_ack_o <= 1'b1;
        end
        ACK: begin
          if (!rd_if.rd_req_i) begin
            state          <= IDLE;
            rd_if.rd_ack_o <= 1'b0;
            rd_if.busy_o   <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          rd_if.rd_ack_o <= 1'b0;
          rd_if.busy_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucsbece154b_bp_perfmon.sv
// Self-checking bench for the branch-predictor performance monitor.
module tb_ucsbece154b_bp_perfmon;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, retire, valid, branch, jump, pt, at, btb;
  logic [31:0] ptg, atg;

  always #5 clk = ~clk;

  ucsbece154b_bp_perfmon_if #(.CNT_W(32), .ADDR_W(3)) rif ();
  ucsbece154b_bp_perfmon_if #(.CNT_W(4),  .ADDR_W(3)) sif ();

  ucsbece154b_bp_perfmon #(.CNT_W(32), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .enable_i(enable), .retire_i(retire),
    .valid_e_i(valid), .branch_e_i(branch), .jump_e_i(jump),
    .pred_taken_e_i(pt), .actual_taken_e_i(at),
    .pred_target_e_i(ptg), .actual_target_e_i(atg),
    .btb_hit_e_i(btb), .rd_if(rif)
  );

  ucsbece154b_bp_perfmon #(.CNT_W(4), .ADDR_W(3)) dut_sat (
    .clk(clk), .reset(reset), .enable_i(enable), .retire_i(retire),
    .valid_e_i(valid), .branch_e_i(branch), .jump_e_i(jump),
    .pred_taken_e_i(pt), .actual_taken_e_i(at),
    .pred_target_e_i(ptg), .actual_target_e_i(atg),
    .btb_hit_e_i(btb), .rd_if(sif)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Reference: counters as plain integers, read protocol as a phase number
  // (0 = waiting for a request, 1 = fetching the value, 2 = acknowledged).
  localparam longint unsigned MAXV = 64'hFFFF_FFFF;
  longint unsigned m_live [8];
  longint unsigned m_snap [8];
  longint unsigned m_data;
  int              m_phase;

  typedef struct packed {
    bit v, b, j, pt, at, tdiff, btb;
    bit [5:0] exp;  // {btb_miss, btb_hit, jmp_misp, jmp, br_misp, br}
  } vec_t;
  vec_t tbl [12];

  function automatic void check(string name, longint unsigned act, longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < 8; i++) begin
      m_live[i] = 0;
      m_snap[i] = 0;
    end
    m_data  = 0;
    m_phase = 0;
  endfunction

  function automatic void model_edge();
    longint unsigned old [8];
    bit ev [8];
    bit vb, vj, bm, jm, clr_acc;
    if (!reset) return;
    old     = m_live;
    clr_acc = rif.clr_req_i && (m_phase == 0);
    vj = valid && jump;
    vb = valid && branch && !jump;
    bm = (pt != at) || (pt && at && (ptg != atg));
    jm = !pt || (ptg != atg);
    ev = '{1'b1, retire, vb, vb && bm, vj, vj && jm, (vb || vj) && btb, (vb || vj) && !btb};
    for (int i = 0; i < 8; i++) begin
      if (clr_acc) m_live[i] = 0;
      else if (enable && ev[i] && (m_live[i] < MAXV)) m_live[i] = m_live[i] + 1;
    end
    case (m_phase)
      0: if (rif.rd_req_i && !rif.clr_req_i) m_phase = 1;
      1: begin
        if (rif.rd_addr_i == 3'd0) begin
          m_snap = old;
          m_data = old[0];
        end else begin
          m_data = m_snap[rif.rd_addr_i];
        end
        m_phase = 2;
      end
      default: if (!rif.rd_req_i) m_phase = 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("ack",  rif.rd_ack_o, (m_phase == 2) ? 1 : 0);
    check("busy", rif.busy_o,   (m_phase != 0) ? 1 : 0);
    check("data", rif.rd_data_o, m_data);
  endtask

  task automatic idle_inputs();
    retire = 0; valid = 0; branch = 0; jump = 0; pt = 0; at = 0; btb = 0;
    ptg = 32'h100; atg = 32'h100;
  endtask

  task automatic clear();
    rif.clr_req_i = 1'b1;
    tick();
    rif.clr_req_i = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] addr, input bit with_clr, output longint unsigned data);
    int n;
    n = 0;
    rif.rd_req_i  = 1'b1;
    rif.rd_addr_i = addr;
    rif.clr_req_i = with_clr;
    tick();
    rif.clr_req_i = 1'b0;
    while (!rif.rd_ack_o && n < 8) begin
      tick();
      n++;
    end
    check("rd_ack_timeout", rif.rd_ack_o, 1);
    data = rif.rd_data_o;
    rif.rd_req_i = 1'b0;
    tick();
  endtask

  initial begin
    longint unsigned d;
    int n;
    tbl[0]  = '{1,1,0,1,1,0,1, 6'b010001};
    tbl[1]  = '{1,1,0,1,1,1,1, 6'b010011};
    tbl[2]  = '{1,1,0,0,1,0,0, 6'b100011};
    tbl[3]  = '{1,1,0,0,0,0,0, 6'b100001};
    tbl[4]  = '{1,1,0,1,0,0,1, 6'b010011};
    tbl[5]  = '{1,0,1,1,1,0,1, 6'b010100};
    tbl[6]  = '{1,0,1,0,1,0,0, 6'b101100};
    tbl[7]  = '{1,0,1,1,1,1,1, 6'b011100};
    tbl[8]  = '{1,1,1,1,1,0,1, 6'b010100};
    tbl[9]  = '{0,1,0,1,0,1,1, 6'b000000};
    tbl[10] = '{1,0,0,1,0,1,1, 6'b000000};
    tbl[11] = '{1,1,0,0,0,1,0, 6'b100001};

    reset = 1'b0; enable = 1'b0; idle_inputs();
    rif.rd_req_i = 0; rif.rd_addr_i = 0; rif.clr_req_i = 0;
    sif.rd_req_i = 0; sif.rd_addr_i = 0; sif.clr_req_i = 0;
    model_zero();
    tick(); tick();
    reset = 1'b1;

    // Reset in the middle of counting and of a read.
    enable = 1; retire = 1;
    repeat (5) tick();
    rif.rd_req_i = 1; rif.rd_addr_i = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("reset_ack_async",  rif.rd_ack_o, 0);
    check("reset_busy_async", rif.busy_o, 0);
    model_zero();
    rif.rd_req_i = 0; enable = 0; retire = 0;
    tick();
    reset = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      do_read(a[2:0], 0, d);
      check($sformatf("reset_cnt%0d", a), d, 0);
    end

    // Snapshot coherence: 10 enabled cycles, 3 retires.
    enable = 1;
    for (int c = 0; c < 10; c++) begin
      retire = (c % 3 == 0) && (c < 9);
      tick();
    end
    enable = 0; retire = 0;
    do_read(0, 0, d);
    check("snap_cnt0", d, 10);
    enable = 1; retire = 1;
    repeat (3) tick();
    do_read(1, 0, d);
    check("snap_cnt1", d, 3);
    enable = 0; retire = 0;

    // Saturation on the 4-bit build: 20 enabled cycles after a reset.
    reset = 1'b0; model_zero(); #1; tick(); reset = 1'b1;
    enable = 1;
    repeat (20) tick();
    enable = 0;
    sif.rd_req_i = 1; sif.rd_addr_i = 0;
    n = 0;
    do begin tick(); n++; end while (!sif.rd_ack_o && n < 8);
    check("sat_ack", sif.rd_ack_o, 1);
    check("sat_cnt0", sif.rd_data_o, 15);
    sif.rd_req_i = 0;
    tick();

    // Table of single-event cases, each from cleared counters.
    for (int r = 0; r < 12; r++) begin
      clear();
      enable = 1;
      valid = tbl[r].v; branch = tbl[r].b; jump = tbl[r].j;
      pt = tbl[r].pt; at = tbl[r].at; btb = tbl[r].btb;
      ptg = 32'h100; atg = tbl[r].tdiff ? 32'h104 : 32'h100;
      tick();
      idle_inputs(); enable = 0;
      do_read(0, 0, d);
      for (int a = 2; a < 8; a++) begin
        do_read(a[2:0], 0, d);
        check($sformatf("tbl%0d_cnt%0d", r, a), d, tbl[r].exp[a-2]);
      end
    end

    // Accumulated branch/jump mix.
    clear();
    enable = 1; valid = 1;
    branch = 1; jump = 0;
    pt = 1; at = 1; ptg = 32'h100; atg = 32'h100; tick();
    pt = 1; at = 1; ptg = 32'h100; atg = 32'h200; tick();
    pt = 0; at = 1; ptg = 32'h100; atg = 32'h100; tick();
    pt = 0; at = 0; tick();
    branch = 0; jump = 1;
    pt = 1; at = 1; ptg = 32'h300; atg = 32'h300; tick();
    pt = 0; at = 1; tick();
    idle_inputs(); enable = 0;
    do_read(0, 0, d);
    do_read(2, 0, d); check("mix_cnt2", d, 4);
    do_read(3, 0, d); check("mix_cnt3", d, 2);
    do_read(4, 0, d); check("mix_cnt4", d, 2);
    do_read(5, 0, d); check("mix_cnt5", d, 1);

    // Handshake timing with the request held five cycles.
    rif.rd_req_i = 1; rif.rd_addr_i = 0;
    tick(); check("hs_ack_c1", rif.rd_ack_o, 0);
    tick(); check("hs_ack_c2", rif.rd_ack_o, 1);
    repeat (3) begin tick(); check("hs_ack_hold", rif.rd_ack_o, 1); end
    rif.rd_req_i = 0;
    tick();
    check("hs_ack_fall", rif.rd_ack_o, 0);
    check("hs_busy_fall", rif.busy_o, 0);

    // Clear wins over a branch event in the same cycle.
    enable = 1; valid = 1; branch = 1; pt = 1; at = 1;
    rif.clr_req_i = 1;
    tick();
    rif.clr_req_i = 0; idle_inputs(); enable = 0;
    do_read(0, 0, d);
    do_read(2, 0, d); check("clr_vs_branch_cnt2", d, 0);

    // Clear during ACK is ignored.
    enable = 1; valid = 1; branch = 1; pt = 1; at = 1;
    tick();
    idle_inputs(); enable = 0;
    rif.rd_req_i = 1; rif.rd_addr_i = 0;
    tick(); tick();
    rif.clr_req_i = 1; tick(); rif.clr_req_i = 0;
    rif.rd_req_i = 0; tick();
    do_read(0, 0, d);
    do_read(2, 0, d); check("clr_in_ack_cnt2", d, 1);

    // Clear and read requested together: clear first, read one cycle later.
    enable = 1;
    do_read(0, 1, d);
    check("clr_with_read_cnt0", d, 1);
    enable = 0;

    // Randomised traffic against the reference.
    for (int c = 0; c < 600; c++) begin
      enable = ($urandom_range(0, 7) != 0);
      retire = $urandom_range(0, 1);
      valid  = $urandom_range(0, 1);
      branch = $urandom_range(0, 1);
      jump   = ($urandom_range(0, 3) == 0);
      pt     = $urandom_range(0, 1);
      at     = $urandom_range(0, 1);
      btb    = $urandom_range(0, 1);
      ptg    = $urandom_range(0, 1) ? 32'h100 : 32'h104;
      atg    = $urandom_range(0, 1) ? 32'h100 : 32'h104;
      rif.clr_req_i = ($urandom_range(0, 9) == 0);
      if (!rif.rd_req_i) begin
        if ($urandom_range(0, 2) == 0) begin
          rif.rd_req_i  = 1;
          rif.rd_addr_i = 3'($urandom_range(0, 7));
        end
      end else if (rif.rd_ack_o && $urandom_range(0, 1)) begin
        rif.rd_req_i = 0;
      end
      tick();
    end
    rif.clr_req_i = 0; rif.rd_req_i = 0; idle_inputs(); enable = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
